alu_cmd_issuer: RTL

ALU_CMD_ISSUER -- requirements
Module: alu_cmd_issuer

---
 rtl/alu_pkg.sv | 18 +
 rtl/alu_cmd_issuer_if.sv | 41 ++++
 rtl/sat_counter.sv | 33 +++
 rtl/alu_cmd_issuer.sv | 87 ++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU opcode constants and the issuer FSM state encoding.
package alu_pkg;

  localparam logic [2:0] OP_NAND = 3'b000;
  localparam logic [2:0] OP_XOR  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_ASR  = 3'b011;
  localparam logic [2:0] OP_OR   = 3'b100;
  localparam logic [2:0] OP_LSL  = 3'b101;
  localparam logic [2:0] OP_NOT  = 3'b110;
  localparam logic [2:0] OP_LT   = 3'b111;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StExec = 2'd1;
  localparam logic [1:0] StCapt = 2'd2;
  localparam logic [1:0] StResp = 2'd3;

endpackage

// File: rtl/alu_cmd_issuer_if.sv
// Command, ALU-drive and response signals of the ALU command issuer.
// The slave modport is the issuer's view; master is the environment's view.
interface alu_cmd_issuer_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned ERR_W = 8
);

  logic             cmd_valid_i;
  logic             cmd_ready_o;
  logic [2:0]       cmd_opcode_i;
  logic [WIDTH-1:0] cmd_first_i;
  logic [WIDTH-1:0] cmd_second_i;
  logic [WIDTH-1:0] cmd_expected_i;

  logic             alu_rst_o;
  logic [2:0]       alu_opcode_o;
  logic [WIDTH-1:0] alu_first_o;
  logic [WIDTH-1:0] alu_second_o;
  logic [WIDTH-1:0] alu_result_i;

  logic             rsp_valid_o;
  logic             rsp_ready_i;
  logic [WIDTH-1:0] rsp_data_o;
  logic             rsp_match_o;
  logic [ERR_W-1:0] err_cnt_o;

  modport slave (
    input  cmd_valid_i, cmd_opcode_i, cmd_first_i, cmd_second_i, cmd_expected_i,
    input  alu_result_i, rsp_ready_i,
    output cmd_ready_o, alu_rst_o, alu_opcode_o, alu_first_o, alu_second_o,
    output rsp_valid_o, rsp_data_o, rsp_match_o, err_cnt_o
  );

  modport master (
    output cmd_valid_i, cmd_opcode_i, cmd_first_i, cmd_second_i, cmd_expected_i,
    output alu_result_i, rsp_ready_i,
    input  cmd_ready_o, alu_rst_o, alu_opcode_o, alu_first_o, alu_second_o,
    input  rsp_valid_o, rsp_data_o, rsp_match_o, err_cnt_o
  );

endinterface

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping; synchronous clear.
module sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         inc_i,
  input  logic         clr_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/alu_cmd_issuer.sv
// Issues one command at a time to an external registered ALU, captures its result,
// compares it against the command's golden value and counts mismatches.
module alu_cmd_issuer
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned ERR_W = 8
) (
  input logic               clk_i,
  input logic               rst_ni,
  alu_cmd_issuer_if.slave   bus
);

  logic [1:0]       state_q, state_d;
  logic             alu_rst_q;
  logic [2:0]       opcode_q;
  logic [WIDTH-1:0] first_q, second_q, expected_q;
  logic [WIDTH-1:0] data_q;
  logic             match_q;
  logic             cmd_ready, accept, capture, mismatch;
  logic [ERR_W-1:0] err_cnt;

  // The ALU is held in reset for one edge past rst_ni release; no issue until it is out.
  assign cmd_ready = (state_q == StIdle) && !alu_rst_q;
  assign accept    = bus.cmd_valid_i && cmd_ready;
  assign capture   = (state_q == StCapt);
  assign mismatch  = capture && (bus.alu_result_i != expected_q);

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (accept) state_d = StExec;
      StExec:  state_d = StCapt;
      StCapt:  state_d = StResp;
      StResp:  if (bus.rsp_ready_i) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      alu_rst_q  <= 1'b1;
      opcode_q   <= '0;
      first_q    <= '0;
      second_q   <= '0;
      expected_q <= '0;
      data_q     <= '0;
      match_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      alu_rst_q <= 1'b0;
      // ALU drive only changes on an accepted command, so it never glitches mid-operation.
      if (accept) begin
        opcode_q   <= bus.cmd_opcode_i;
        first_q    <= bus.cmd_first_i;
        second_q   <= bus.cmd_second_i;
        expected_q <= bus.cmd_expected_i;
      end
      if (capture) begin
        data_q  <= bus.alu_result_i;
        match_q <= (bus.alu_result_i == expected_q);
      end
    end
  end

  sat_counter #(
    .W (ERR_W)
  ) u_err_cnt (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .inc_i  (mismatch),
    .clr_i  (alu_rst_q),
    .cnt_o  (err_cnt)
  );

  assign bus.cmd_ready_o  = cmd_ready;
  assign bus.alu_rst_o    = alu_rst_q;
  assign bus.alu_opcode_o = opcode_q;
  assign bus.alu_first_o  = first_q;
  assign bus.alu_second_o = second_q;
  assign bus.rsp_valid_o  = (state_q == StResp);
  assign bus.rsp_data_o   = data_q;
  assign bus.rsp_match_o  = match_q;
  assign bus.err_cnt_o    = err_cnt;

endmodule
